// File: rtl/alu_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_core_pkg
// Description : Opcode and FSM state types shared by the ALU core and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_core_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'd0,
        add_op = 3'd1,
        and_op = 3'd2,
        xor_op = 3'd3,
        mul_op = 3'd4,
        rst_op = 3'd7
    } alu_op_t;

    typedef logic [1:0] alu_state_t;

    localparam alu_state_t c_st_idle = 2'd0;
    localparam alu_state_t c_st_mul  = 2'd1;
    localparam alu_state_t c_st_done = 2'd2;

    // Counter width able to hold w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core_mul.sv
`default_nettype none
// ============================================================================
// Module      : alu_core_mul
// Description : Iterative shift-add unsigned multiplier, one operand bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core_mul
    import alu_core_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 last,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_cnt_w = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= c_cnt_w'(WIDTH - 1);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
        end
    end

    // product already folds in the current step so the final value is ready
    // on the same edge the last bit is consumed.
    assign busy    = r_busy;
    assign last    = r_busy && (r_cnt == '0);
    assign product = w_acc_next;

endmodule
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Handshaked ALU with add/and/xor/mul and a 2W-bit result reg.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_core_pkg::*;
#(
    parameter int ALU_IN_OP_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  alu_op_t                        alu_op,
    input  logic [ALU_IN_OP_WIDTH-1:0]     a,
    input  logic [ALU_IN_OP_WIDTH-1:0]     b,
    input  logic                           valid,
    output logic                           ready,
    output logic                           done,
    output logic [2*ALU_IN_OP_WIDTH-1:0]   result
);

    alu_state_t                         r_state;
    alu_state_t                         w_state_next;
    logic                               w_load_alu;
    logic                               w_load_mul;
    logic                               w_clear;
    logic                               w_mul_start;
    logic                               w_mul_busy;
    logic                               w_mul_last;
    logic [ALU_IN_OP_WIDTH:0]           w_sum;
    logic [2*ALU_IN_OP_WIDTH-1:0]       w_alu_res;
    logic [2*ALU_IN_OP_WIDTH-1:0]       w_mul_product;
    logic [2*ALU_IN_OP_WIDTH-1:0]       r_result;

    alu_core_mul #(
        .WIDTH   (ALU_IN_OP_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (a),
        .b       (b),
        .busy    (w_mul_busy),
        .last    (w_mul_last),
        .product (w_mul_product)
    );

    assign w_sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        w_alu_res = '0;
        case (alu_op)
            add_op:  w_alu_res[ALU_IN_OP_WIDTH:0]   = w_sum;
            and_op:  w_alu_res[ALU_IN_OP_WIDTH-1:0] = a & b;
            xor_op:  w_alu_res[ALU_IN_OP_WIDTH-1:0] = a ^ b;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_alu   = 1'b0;
        w_load_mul   = 1'b0;
        w_clear      = 1'b0;
        w_mul_start  = 1'b0;
        ready        = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_st_idle: begin
                ready = 1'b1;
                if (valid) begin
                    case (alu_op)
                        add_op, and_op, xor_op: begin
                            w_load_alu   = 1'b1;
                            w_state_next = c_st_done;
                        end
                        mul_op: begin
                            w_mul_start  = 1'b1;
                            w_state_next = c_st_mul;
                        end
                        rst_op:  w_clear = 1'b1;
                        default: ;
                    endcase
                end
            end
            c_st_mul: begin
                if (w_mul_last) begin
                    w_load_mul   = 1'b1;
                    w_state_next = c_st_done;
                end else if (!w_mul_busy) begin
                    // Multiplier lost its operation; do not hang here.
                    w_state_next = c_st_idle;
                end
            end
            c_st_done: begin
                done         = 1'b1;
                w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_clear) begin
            r_result <= '0;
        end else if (w_load_alu) begin
            r_result <= w_alu_res;
        end else if (w_load_mul) begin
            r_result <= w_mul_product;
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_core
// Description : Directed plus random self-checking bench for alu_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_core;
    import alu_core_pkg::*;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    alu_op_t        alu_op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           valid;
    logic           ready;
    logic           done;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    logic [2*W-1:0] model_result = '0;

    alu_core #(
        .ALU_IN_OP_WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .alu_op (alu_op),
        .a      (a),
        .b      (b),
        .valid  (valid),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && ready !== 1'b1; i++) tick();
        check("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    // Issue one request and follow it to completion against the model.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input bit poke_mid);
        int lat;
        logic [2*W-1:0] exp_r;
        wait_ready();
        alu_op = alu_op_t'(op);
        a      = ia;
        b      = ib;
        valid  = 1'b1;
        tick();
        valid  = 1'b0;
        a      = W'($urandom);
        b      = W'($urandom);
        exp_r  = model_result;
        lat    = 0;
        case (op)
            3'd1: begin exp_r = (2*W)'(ia) + (2*W)'(ib); lat = 1; end
            3'd2: begin exp_r = (2*W)'(ia & ib);         lat = 1; end
            3'd3: begin exp_r = (2*W)'(ia ^ ib);         lat = 1; end
            3'd4: begin exp_r = (2*W)'(ia) * (2*W)'(ib); lat = W + 1; end
            3'd7: exp_r = '0;
            default: ;
        endcase
        if (lat == 0) begin
            check("nodone_done", {63'd0, done}, 64'd0);
            check("nodone_ready", {63'd0, ready}, 64'd1);
            check("nodone_result", 64'(result), 64'(exp_r));
        end else begin
            for (int i = 0; i < lat; i++) begin
                if (poke_mid && i == 1) begin
                    alu_op = add_op;
                    valid  = 1'b1;
                end
                check("busy_ready", {63'd0, ready}, 64'd0);
                if (i == lat - 1) begin
                    valid = 1'b0;
                    check("done_pulse", {63'd0, done}, 64'd1);
                    check("done_result", 64'(result), 64'(exp_r));
                    last_done_cyc = cyc;
                    tick();
                end else begin
                    check("early_done", {63'd0, done}, 64'd0);
                    tick();
                end
            end
            check("post_done", {63'd0, done}, 64'd0);
            check("post_ready", {63'd0, ready}, 64'd1);
            check("post_result", 64'(result), 64'(exp_r));
        end
        model_result = exp_r;
    endtask

    initial begin
        int d1;
        int n;
        rst    = 1'b1;
        valid  = 1'b0;
        alu_op = no_op;
        a      = '0;
        b      = '0;
        #2;
        check("reset_ready", {63'd0, ready}, 64'd1);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", 64'(result), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // First edge after reset release must already accept.
        do_op(3'd1, 8'hFF, 8'h01, 1'b0);
        do_op(3'd4, 8'hFF, 8'hFF, 1'b1);

        do_op(3'd2, 8'hF0, 8'h3C, 1'b0);
        d1 = last_done_cyc;
        do_op(3'd3, 8'hF0, 8'h3C, 1'b0);
        check("b2b_spacing", 64'(last_done_cyc - d1), 64'd2);

        do_op(3'd1, 8'h12, 8'h34, 1'b0);
        do_op(3'd7, 8'hAA, 8'h55, 1'b0);
        do_op(3'd5, 8'h11, 8'h22, 1'b0);

        // Reset in the middle of a multiply.
        wait_ready();
        do_op(3'd1, 8'h05, 8'h06, 1'b0);
        alu_op = mul_op;
        a      = 8'h10;
        b      = 8'h10;
        valid  = 1'b1;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_ready", {63'd0, ready}, 64'd1);
        check("abort_result", 64'(result), 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        tick();
        rst = 1'b0;
        model_result = '0;
        n = 0;
        repeat (W + 4) begin
            tick();
            if (done === 1'b1) n++;
        end
        check("abort_no_done", 64'(n), 64'd0);

        // valid held through DONE is taken exactly once, in IDLE.
        wait_ready();
        alu_op = add_op;
        a      = 8'h20;
        b      = 8'h05;
        valid  = 1'b1;
        tick();
        check("hold_first_done", {63'd0, done}, 64'd1);
        check("hold_first_result", 64'(result), 64'h25);
        a = 8'h01;
        b = 8'h02;
        tick();
        check("hold_idle_done", {63'd0, done}, 64'd0);
        check("hold_idle_ready", {63'd0, ready}, 64'd1);
        tick();
        valid = 1'b0;
        check("hold_second_done", {63'd0, done}, 64'd1);
        check("hold_second_result", 64'(result), 64'h03);
        model_result = 16'h0003;
        n = 0;
        repeat (6) begin
            tick();
            if (done === 1'b1) n++;
        end
        check("hold_single_done", 64'(n), 64'd0);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                  bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
